// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one partial-product step per clock with a start/busy/d_end handshake.
// Optional macro MULT_SIGNED_EN: two's-complement operands via magnitude/sign around the unsigned core.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 d_end,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               d_end_q, d_end_d;
  logic [WIDTH:0]     acc_s;
  logic [2*WIDTH-1:0] prod_s;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // The magnitude is kept unsigned, so 2^(WIDTH-1) (from the most-negative operand) still fits.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic s, input logic [2*WIDTH-1:0] p);
    if (s) begin
      return ~p + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return p;
    end
  endfunction
`endif

  // Next-state, datapath step and output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    b_d      = b_q;
    c_d      = c_q;
    count_d  = count_q;
    result_d = result_q;
`ifdef MULT_SIGNED_EN
    sign_d   = sign_q;
`endif
    acc_s  = {c_q, a_q} + (q_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    prod_s = {acc_s[WIDTH:1], acc_s[0], q_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = {WIDTH{1'b0}};
          c_d     = 1'b0;
          count_d = {CW{1'b0}};
`ifdef MULT_SIGNED_EN
          b_d     = abs_val(b);
          q_d     = abs_val(q);
          sign_d  = b[WIDTH-1] ^ q[WIDTH-1];
`else
          b_d     = b;
          q_d     = q;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // {C,A,Q} shifted right after the conditional add; C is always cleared.
        a_d     = acc_s[WIDTH:1];
        q_d     = {acc_s[0], q_q[WIDTH-1:1]};
        c_d     = 1'b0;
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (count_q == LAST_STEP) begin
          state_d = S_DONE;
`ifdef MULT_SIGNED_EN
          result_d = apply_sign(sign_q, prod_s);
`else
          result_d = prod_s;
`endif
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_RUN);
    d_end_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      q_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      c_q      <= 1'b0;
      count_q  <= {CW{1'b0}};
      result_q <= {(2*WIDTH){1'b0}};
      busy_q   <= 1'b0;
      d_end_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      b_q      <= b_d;
      c_q      <= c_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      d_end_q  <= d_end_d;
`ifdef MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign d_end  = d_end_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: cycle-level reference model plus directed vectors with literal expectations.
module tb_seq_shift_add_mult;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  b, q;
  logic          busy, d_end;
  logic [2*W-1:0] result;

  logic          start16;
  logic [15:0]   b16, q16;
  logic          busy16, dend16;
  logic [31:0]   res16;

  int total = 0;
  int bad   = 0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .b(b), .q(q),
    .busy(busy), .d_end(d_end), .result(result)
  );

  seq_shift_add_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .b(b16), .q(q16),
    .busy(busy16), .d_end(dend16), .result(res16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULT_SIGNED_EN
    logic signed [2*W-1:0] p;
    p = $signed(x) * $signed(y);
    return p;
`else
    return (2*W)'(x) * (2*W)'(y);
`endif
  endfunction

  // Reference model: an accepted start yields W busy cycles, then one d_end cycle with the product.
  int             run_left = 0;
  logic [2*W-1:0] pend     = '0;
  logic [2*W-1:0] exp_res  = '0;
  logic           exp_dend = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run_left <= 0;
      exp_dend <= 1'b0;
      exp_res  <= '0;
    end else begin
      exp_dend <= (run_left == 1);
      if (run_left == 1) exp_res <= pend;
      if (run_left == 0 && start) begin
        run_left <= W;
        pend     <= ref_prod(b, q);
      end else if (run_left > 0) begin
        run_left <= run_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, run_left > 0);
    check("d_end", d_end, exp_dend);
    check("result", result, exp_res);
  end

  task automatic run_op(input logic [W-1:0] bv, input logic [W-1:0] qv,
                        input logic [2*W-1:0] exp, input string nm);
    int n;
    int nbusy;
    @(negedge clk);
    start = 1'b1; b = bv; q = qv;
    n = 0; nbusy = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nbusy++;
    end while (!d_end && n < 30);
    check({nm, " latency"}, n, 9);
    check({nm, " busy cycles"}, nbusy, 8);
    check({nm, " result"}, result, exp);
    @(negedge clk);
    check({nm, " held"}, result, exp);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; start = 1'b0; b = '0; q = '0;
    start16 = 1'b0; b16 = '0; q16 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset d_end", d_end, 1'b0);
    check("reset result", result, 16'h0000);
    rst = 1'b0;

`ifdef MULT_SIGNED_EN
    run_op(8'd5,   8'd3,   16'd15,   "5x3");
    run_op(8'hFD,  8'd5,   16'hFFF1, "-3x5");
    run_op(8'h80,  8'h80,  16'd16384, "-128x-128");
    run_op(8'd127, 8'hFF,  16'hFF81, "127x-1");
    run_op(8'd0,   8'd0,   16'd0,    "0x0");
`else
    run_op(8'd5,   8'd3,   16'd15,    "5x3");
    run_op(8'd255, 8'd255, 16'hFE01,  "255x255");
    run_op(8'd127, 8'd201, 16'd25527, "127x201");
    run_op(8'd0,   8'd0,   16'd0,     "0x0");
    run_op(8'd128, 8'd128, 16'd16384, "128x128");
`endif

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    start = 1'b1; b = 8'd7; q = 8'd9;
    @(negedge clk);
    b = 8'd10; q = 8'd12;
    n = 1;
    while (!d_end && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", n, 9);
    check("b2b first result", result, 16'd63);
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!d_end && n < 30);
    check("b2b d_end spacing", n, 9);
    check("b2b second result", result, 16'd120);

    // Start during busy must be ignored.
    @(negedge clk);
    start = 1'b1; b = 8'd4; q = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    b = 8'd8; q = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!d_end && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ignored start result", result, 16'd16);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (d_end) pulses++;
    end
    check("ignored start extra d_end", pulses, 0);

    // Reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; b = 8'd9; q = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy before reset", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset d_end", d_end, 1'b0);
    check("async reset result", result, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd2, 8'd2, 16'd4, "2x2 after reset");

    // Wide configuration.
    @(negedge clk);
    start16 = 1'b1; b16 = 16'hFFFF; q16 = 16'hFFFF;
    n = 0;
    do begin
      @(negedge clk);
      start16 = 1'b0;
      n++;
    end while (!dend16 && n < 60);
    check("w16 latency", n, 17);
`ifdef MULT_SIGNED_EN
    check("w16 result", res16, 32'h0000_0001);
`else
    check("w16 result", res16, 32'hFFFE_0001);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
